multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised, handshaked successor to the single-cycle combinational ALU of the core datapath. It executes the base integer op set (ADD…SLTU) with one-cycle latency. It adds iterative multiply, divide and remainder ops, which take WIDTH+1 cycles. Sits in the execute stage between operand fetch and writeback, with valid/ready on both sides so the pipeline stalls on long ops.

## Interface
Parameters:
- WIDTH, 32, operand/result width; even, ≥ 8.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  block can accept an op this cycle.
- A  in  WIDTH  operand 1 (rs1).
- B  in  WIDTH  operand 2 (rs2/imm); shifts use B[$clog2(WIDTH)-1:0].
- ALU_control  in  5  op select (encodings under Operation).
- out_valid  out  1  rd/Zero hold a completed result.
- out_ready  in  1  consumer takes result this cycle.
- rd  out  WIDTH  result, registered.
- Zero  out  1  registered, 1 iff rd == 0.
- busy  out  1  iterative op in progress.

## Operation
- Accept when in_valid && in_ready. A, B and ALU_control are captured at accept; later input changes have no effect.
- Base ops, 1-cycle: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA, 01000 SLT (signed), 01001 SLTU. SLT/SLTU give rd = {0…0, flag}. Arithmetic wraps modulo 2^WIDTH.
- Iterative ops: 01010 MUL (low WIDTH bits), 01011 MULHU (high WIDTH bits, unsigned), 01100 DIVU, 01101 REMU, 01110 DIV, 01111 REM.
  - Multiply: shift-add, one bit per cycle.
  - Divide: restoring division on magnitudes; result sign fixed after the last iteration. Quotient truncates toward zero; remainder takes the dividend's sign.
- Division special cases, resolved at accept with 1-cycle latency, no iteration:
  - B == 0: quotient = all ones, remainder = A.
  - DIV/REM with A = most-negative and B = −1: quotient = A, remainder = 0.
- Codes 10000–11111: rd = 0, Zero = 1, 1-cycle latency.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept a base or special-case op → DONE; accept an iterative op → BUSY.
  - BUSY: after the WIDTH-th iteration → DONE.
  - DONE, out_ready = 1: with no new accept → IDLE; otherwise behaves as an accept from IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- busy = (state == BUSY).
- out_valid = (state == DONE).

## Timing
- Reset values: state IDLE; in_ready 1, out_valid 0, busy 0, rd 0, Zero 0; iteration counter and datapath registers 0.
- Latency from the accept edge to out_valid high:
  - base ops and special cases: 1 cycle;
  - iterative ops: WIDTH+1 cycles (WIDTH cycles in BUSY, then DONE).
- Throughput:
  - base ops: 1 per cycle under continuous out_ready;
  - iterative ops: 1 per WIDTH+1 cycles.
- Backpressure: while out_valid && !out_ready, rd, Zero and out_valid hold stable and in_ready = 0.
- Same-cycle out_ready and accept in DONE: the old result retires and the new op starts on the same edge, with no bubble.
- in_valid while BUSY: ignored (in_ready = 0); the op is not lost because the upstream stage must hold it.
- rst asserted mid-BUSY or in DONE: immediate abort, no result is produced, and all outputs take their reset values asynchronously.
- Iteration counter width: $clog2(WIDTH)+1; no wrap within an op.

## Structure
- Package alu_pkg holds:
  - the 5-bit op-code localparams;
  - the FSM state encoding (IDLE/BUSY/DONE);
  - the helper function is_iterative(op).
- Sub-module muldiv_iter contains the shift-add/restoring datapath, counter, and sign pre/post-correction. Its handshake is start/done; the top keeps the FSM, the base-op combinational logic, and the output registers.

## Test plan
All scenarios at WIDTH = 32.
- ADD A=1, B=2 → rd=3, Zero=0, out_valid 1 cycle after accept. SUB A=2, B=2 → rd=0, Zero=1.
- Shifts and compares:
  - SRA A=0x8000_0000, B=4 → 0xF800_0000; SRL same operands → 0x0800_0000.
  - SLT A=0xFFFF_FFFF, B=1 → 1; SLTU same operands → 0.
  - SLL B=33 → same result as shift by 1.
- Multiply:
  - MUL A=0xFFFF_FFFF, B=2 → 0xFFFF_FFFE, out_valid exactly 33 cycles after accept.
  - MULHU same operands → 0x0000_0001.
  - busy high for 32 cycles.
- Divide:
  - DIV −7/2 → 0xFFFF_FFFD; REM −7/2 → 0xFFFF_FFFF.
  - DIVU 7/0 → 0xFFFF_FFFF with 1-cycle latency; REMU 7/0 → 7.
  - REM 0x8000_0000 / −1 → 0, Zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL result → rd stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 (ADD 3+4) on the same cycle → new op accepted on that edge; rd=7 one cycle later.
- Reset mid-op: assert rst at iteration 10 of a DIV → out_valid=0, busy=0, rd=0 immediately. After release, ADD 5+5 → rd=10 with normal 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg                                                              |
// | Op-code map, FSM state encoding and op classification helper.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam logic [4:0] c_op_add   = 5'b00000;
  localparam logic [4:0] c_op_sub   = 5'b00001;
  localparam logic [4:0] c_op_and   = 5'b00010;
  localparam logic [4:0] c_op_or    = 5'b00011;
  localparam logic [4:0] c_op_xor   = 5'b00100;
  localparam logic [4:0] c_op_sll   = 5'b00101;
  localparam logic [4:0] c_op_srl   = 5'b00110;
  localparam logic [4:0] c_op_sra   = 5'b00111;
  localparam logic [4:0] c_op_slt   = 5'b01000;
  localparam logic [4:0] c_op_sltu  = 5'b01001;
  localparam logic [4:0] c_op_mul   = 5'b01010;
  localparam logic [4:0] c_op_mulhu = 5'b01011;
  localparam logic [4:0] c_op_divu  = 5'b01100;
  localparam logic [4:0] c_op_remu  = 5'b01101;
  localparam logic [4:0] c_op_div   = 5'b01110;
  localparam logic [4:0] c_op_rem   = 5'b01111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [4:0] op);
    return (op >= c_op_mul) && (op <= c_op_rem);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// +----------------------------------------------------------------------+
// | muldiv_iter                                                          |
// | Bit-serial shift-add multiplier / restoring divider, start/done.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int c_cnt_w = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  logic               r_run;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;
  logic [4:0]         r_op;
  logic               r_neg_q;
  logic               r_neg_r;

  logic             w_is_mul;
  logic             w_sgn;
  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_is_mul = (r_op == c_op_mul) || (r_op == c_op_mulhu);
  assign w_sgn    = (i_op == c_op_div) || (i_op == c_op_rem);
  assign w_last   = r_run && (r_cnt == c_last);
  assign w_a_mag  = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_b_mag  = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
  assign o_done   = w_last;

  // hi:lo is the product accumulator for multiply, remainder:quotient for divide
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_fits  = (w_shift >= {1'b0, r_b});
    w_sub   = w_shift[WIDTH-1:0] - r_b;
    if (w_is_mul) begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_hi_n = w_fits ? w_sub : w_shift[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_fits};
    end
    case (r_op)
      c_op_mul:   o_result = w_lo_n;
      c_op_mulhu: o_result = w_hi_n;
      c_op_divu:  o_result = w_lo_n;
      c_op_remu:  o_result = w_hi_n;
      c_op_div:   o_result = r_neg_q ? -w_lo_n : w_lo_n;
      c_op_rem:   o_result = r_neg_r ? -w_hi_n : w_hi_n;
      default:    o_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_b     <= w_b_mag;
      r_op    <= i_op;
      r_neg_q <= w_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r <= w_sgn && i_a[WIDTH-1];
    end else if (r_run) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_alu.sv
// +----------------------------------------------------------------------+
// | multicycle_alu                                                       |
// | Handshaked execute-stage ALU: 1-cycle base ops, iterative mul/div.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             Zero,
  output logic             busy
);

  localparam int c_sh_w = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_rd;
  logic             r_zero;

  logic              w_accept;
  logic              w_start;
  logic              w_special;
  logic              w_b_zero;
  logic              w_ovf;
  logic [c_sh_w-1:0] w_shamt;
  logic [WIDTH-1:0]  w_base_result;
  logic              w_md_done;
  logic [WIDTH-1:0]  w_md_result;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign rd        = r_rd;
  assign Zero      = r_zero;

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = B[c_sh_w-1:0];
  assign w_b_zero = (B == '0);
  assign w_ovf    = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

  // Divide corner cases bypass the iterative unit and retire like base ops
  always_comb begin
    w_special = 1'b0;
    if ((ALU_control == c_op_divu) || (ALU_control == c_op_remu)) begin
      w_special = w_b_zero;
    end else if ((ALU_control == c_op_div) || (ALU_control == c_op_rem)) begin
      w_special = w_b_zero || w_ovf;
    end
  end

  assign w_start = w_accept && is_iterative(ALU_control) && !w_special;

  always_comb begin
    w_base_result = '0;
    case (ALU_control)
      c_op_add:  w_base_result = A + B;
      c_op_sub:  w_base_result = A - B;
      c_op_and:  w_base_result = A & B;
      c_op_or:   w_base_result = A | B;
      c_op_xor:  w_base_result = A ^ B;
      c_op_sll:  w_base_result = A << w_shamt;
      c_op_srl:  w_base_result = A >> w_shamt;
      c_op_sra:  w_base_result = $signed(A) >>> w_shamt;
      c_op_slt:  w_base_result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      c_op_sltu: w_base_result = {{(WIDTH-1){1'b0}}, A < B};
      c_op_divu: w_base_result = '1;
      c_op_remu: w_base_result = A;
      c_op_div:  w_base_result = w_b_zero ? '1 : A;
      c_op_rem:  w_base_result = w_b_zero ? A : '0;
      default:   w_base_result = '0;
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv_iter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_op     (ALU_control),
    .i_a      (A),
    .i_b      (B),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd    <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_start) begin
              r_state <= BUSY;
            end else begin
              r_state <= DONE;
              r_rd    <= w_base_result;
              r_zero  <= (w_base_result == '0);
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          if (w_md_done) begin
            r_state <= DONE;
            r_rd    <= w_md_result;
            r_zero  <= (w_md_result == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_alu                                                    |
// | Scenario tasks checked against an arithmetic reference model.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_alu;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [4:0]   ALU_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rd;
  logic         Zero;
  logic         busy;

  int n_checks;
  int n_pass;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rd          (rd),
    .Zero        (Zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  function automatic logic ref_special(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op == 5'd12 || op == 5'd13) return b == 0;
    if (op == 5'd14 || op == 5'd15) return (b == 0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return 1'b0;
  endfunction

  function automatic int ref_lat(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op >= 5'd10 && op <= 5'd15 && !ref_special(op, a, b)) return W + 1;
    return 1;
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0]    sh;
    logic [63:0]   p;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sh = b[4:0];
    sa = a;
    sb = b;
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << sh;
      5'd6:  return a >> sh;
      5'd7:  return sa >>> sh;
      5'd8:  return {31'd0, sa < sb};
      5'd9:  return {31'd0, a < b};
      5'd10: return p[31:0];
      5'd11: return p[63:32];
      5'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd13: return (b == 0) ? a : a % b;
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      5'd15: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rdy, output int lat, output logic [W-1:0] res,
                       output logic zr, output int bcnt);
    int guard;
    @(negedge clk);
    in_valid    = 1'b1;
    ALU_control = op;
    A           = a;
    B           = b;
    out_ready   = rdy;
    guard       = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    A           = $urandom;
    B           = $urandom;
    ALU_control = 5'($urandom);
    lat  = 1;
    bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = rd;
    zr  = Zero;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A = '0; B = '0; ALU_control = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, Zero, rd} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0})
      $display("FAIL reset: got ready/valid/busy/zero/rd=%b%b%b%b/%h want 1000/0",
               in_ready, out_valid, busy, Zero, rd);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_base_directed();
    vec_t tbl[8];
    int lat, bc;
    logic [W-1:0] res;
    logic zr;
    tbl[0] = '{5'd0, 32'd1,         32'd2,  32'd3,         1};
    tbl[1] = '{5'd1, 32'd2,         32'd2,  32'd0,         1};
    tbl[2] = '{5'd7, 32'h8000_0000, 32'd4,  32'hF800_0000, 1};
    tbl[3] = '{5'd6, 32'h8000_0000, 32'd4,  32'h0800_0000, 1};
    tbl[4] = '{5'd8, 32'hFFFF_FFFF, 32'd1,  32'd1,         1};
    tbl[5] = '{5'd9, 32'hFFFF_FFFF, 32'd1,  32'd0,         1};
    tbl[6] = '{5'd5, 32'h0000_0003, 32'd33, 32'd6,         1};
    tbl[7] = '{5'd19, 32'd5,        32'd5,  32'd0,         1};
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, lat, res, zr, bc);
      n_checks++;
      if ({zr, res} !== {tbl[i].exp == 32'd0, tbl[i].exp})
        $display("FAIL base_dir[%0d] op=%0d: rd=%h Zero=%b want rd=%h Zero=%b",
                 i, tbl[i].op, res, zr, tbl[i].exp, tbl[i].exp == 32'd0);
      else n_pass++;
      n_checks++;
      if (lat !== tbl[i].lat)
        $display("FAIL base_dir_lat[%0d]: latency=%0d want %0d", i, lat, tbl[i].lat);
      else n_pass++;
    end
  endtask

  task automatic test_base_random();
    int lat, bc;
    logic [W-1:0] res, a, b, exp;
    logic [4:0] op;
    logic zr;
    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 9));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exp = ref_alu(op, a, b);
      do_op(op, a, b, 1'b1, lat, res, zr, bc);
      n_checks++;
      if ({zr, res, lat} !== {exp == 32'd0, exp, 32'd1})
        $display("FAIL base_rand op=%0d a=%h b=%h: rd=%h Zero=%b lat=%0d want rd=%h Zero=%b lat=1",
                 op, a, b, res, zr, lat, exp, exp == 32'd0);
      else n_pass++;
    end
  endtask

  task automatic test_mul();
    int lat, bc;
    logic [W-1:0] res, a, b, exp;
    logic [4:0] op;
    logic zr;
    do_op(5'd10, 32'hFFFF_FFFF, 32'd2, 1'b1, lat, res, zr, bc);
    n_checks++;
    if (res !== 32'hFFFF_FFFE) $display("FAIL mul_value: rd=%h want fffffffe", res);
    else n_pass++;
    n_checks++;
    if (lat !== 33) $display("FAIL mul_latency: latency=%0d want 33", lat);
    else n_pass++;
    n_checks++;
    if (bc !== 32) $display("FAIL mul_busy_cycles: busy cycles=%0d want 32", bc);
    else n_pass++;
    do_op(5'd11, 32'hFFFF_FFFF, 32'd2, 1'b1, lat, res, zr, bc);
    n_checks++;
    if ({zr, res} !== {1'b0, 32'd1}) $display("FAIL mulhu_value: rd=%h Zero=%b want 00000001 0", res, zr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      op  = 5'($urandom_range(10, 11));
      a   = $urandom;
      b   = (i == 0) ? 32'd0 : $urandom;
      exp = ref_alu(op, a, b);
      do_op(op, a, b, 1'b1, lat, res, zr, bc);
      n_checks++;
      if ({zr, res, lat} !== {exp == 32'd0, exp, 32'd33})
        $display("FAIL mul_rand op=%0d a=%h b=%h: rd=%h Zero=%b lat=%0d want rd=%h lat=33",
                 op, a, b, res, zr, lat, exp);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    vec_t tbl[5];
    int lat, bc, elat;
    logic [W-1:0] res, a, b, exp;
    logic [4:0] op;
    logic zr;
    int sel;
    tbl[0] = '{5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    tbl[1] = '{5'd15, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    tbl[2] = '{5'd12, 32'd7,         32'd0,         32'hFFFF_FFFF, 1};
    tbl[3] = '{5'd13, 32'd7,         32'd0,         32'd7,         1};
    tbl[4] = '{5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    for (int i = 0; i < 5; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, lat, res, zr, bc);
      n_checks++;
      if ({zr, res, lat} !== {tbl[i].exp == 32'd0, tbl[i].exp, tbl[i].lat})
        $display("FAIL div_dir[%0d] op=%0d: rd=%h Zero=%b lat=%0d want rd=%h Zero=%b lat=%0d",
                 i, tbl[i].op, res, zr, lat, tbl[i].exp, tbl[i].exp == 32'd0, tbl[i].lat);
      else n_pass++;
    end
    for (int i = 0; i < 14; i++) begin
      op  = 5'($urandom_range(12, 15));
      a   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = -32'($urandom_range(1, 15));
      else               b = $urandom;
      exp  = ref_alu(op, a, b);
      elat = ref_lat(op, a, b);
      do_op(op, a, b, 1'b1, lat, res, zr, bc);
      n_checks++;
      if ({zr, res, lat} !== {exp == 32'd0, exp, elat})
        $display("FAIL div_rand op=%0d a=%h b=%h: rd=%h Zero=%b lat=%0d want rd=%h lat=%0d",
                 op, a, b, res, zr, lat, exp, elat);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, exp;
    logic [4:0] op;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      op = 5'($urandom_range(0, 9));
      a  = $urandom;
      b  = $urandom;
      exp = ref_alu(op, a, b);
      in_valid = 1'b1; out_ready = 1'b1;
      ALU_control = op; A = a; B = b;
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, rd} !== {1'b1, 1'b1, exp})
        $display("FAIL back_to_back[%0d] op=%0d: valid=%b ready=%b rd=%h want 1 1 %h",
                 i, op, out_valid, in_ready, rd, exp);
      else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat, bc;
    logic [W-1:0] res;
    logic zr;
    do_op(5'd10, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, res, zr, bc);
    n_checks++;
    if ({res, lat} !== {32'hFFFF_FFFE, 32'd33})
      $display("FAIL bp_mul: rd=%h lat=%0d want fffffffe 33", res, lat);
    else n_pass++;
    @(negedge clk);
    in_valid = 1'b1; ALU_control = 5'd0; A = 32'd3; B = 32'd4; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, in_ready, rd} !== {1'b1, 1'b0, 32'hFFFF_FFFE})
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b rd=%h want 1 0 fffffffe",
                 i, out_valid, in_ready, rd);
      else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, rd, Zero} !== {1'b1, 32'd7, 1'b0})
      $display("FAIL bp_next_add: valid=%b rd=%h Zero=%b want 1 00000007 0", out_valid, rd, Zero);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int lat, bc;
    logic [W-1:0] res;
    logic zr;
    do_op(5'd0, 32'h1234, 32'd1, 1'b1, lat, res, zr, bc);
    @(negedge clk);
    in_valid = 1'b1; ALU_control = 5'd14; A = -32'd100; B = 32'd3; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_checks++;
    if ({busy, out_valid, rd} !== {1'b1, 1'b0, 32'h1235})
      $display("FAIL rst_pre: busy=%b valid=%b rd=%h want 1 0 00001235", busy, out_valid, rd);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, busy, in_ready, Zero, rd} !== {1'b0, 1'b0, 1'b1, 1'b0, 32'd0})
      $display("FAIL rst_mid_op: valid/busy/ready/zero=%b%b%b%b rd=%h want 0010 0",
               out_valid, busy, in_ready, Zero, rd);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_op(5'd0, 32'd5, 32'd5, 1'b1, lat, res, zr, bc);
    n_checks++;
    if ({res, lat} !== {32'd10, 32'd1})
      $display("FAIL rst_after_add: rd=%h lat=%0d want 0000000a 1", res, lat);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_base_directed();
    test_base_random();
    test_mul();
    test_div();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
